counter_handshake_env: RTL

//  Clocked 4-phase environment for the asynchronous handshake counter chain.
//  - Initiator on the counter's input channel: drives ri, waits on ai.
//  - Responder on its output channel: watches ro, drives ao.
//  - Issues a programmed number of input handshakes and counts completed output handshakes.
//  - Flags protocol violations and timeouts, so the chain can be run and checked in synchronous sims.

---
 rtl/counter_handshake_env.sv | 335 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/counter_handshake_env.sv
`default_nettype none
// ============================================================================
//  Module   : counter_handshake_env
//  Brief    : Clocked 4-phase environment for an asynchronous handshake
//             counter chain. Initiates a programmed number of handshakes on
//             the chain's input channel (ri/ai), acknowledges every handshake
//             on its output channel (ro/ao), counts both and flags protocol
//             violations and ai timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_handshake_env #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 1,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_req,
  output logic             busy,
  output logic             done,
  output logic             ri,
  input  logic             ai,
  input  logic             ro,
  output logic             ao,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] out_count,
  output logic             proto_err,
  output logic [1:0]       err_code
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_tmo_w = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int c_dly_w = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  localparam logic [c_tmo_w-1:0] c_tmo_max  = c_tmo_w'(TIMEOUT);
  localparam logic [c_dly_w-1:0] c_dly_last = c_dly_w'((ACK_DELAY > 0) ? ACK_DELAY - 1 : 0);

  localparam logic [1:0] c_err_tmo  = 2'b01;
  localparam logic [1:0] c_err_spur = 2'b10;
  localparam logic [1:0] c_err_ro   = 2'b11;

  typedef enum logic [2:0] {
    IN_IDLE   = 3'd0,
    IN_REQ_UP = 3'd1,
    IN_REQ_DN = 3'd2,
    IN_FIN    = 3'd3,
    IN_ERR    = 3'd4
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_WAIT_RISE = 2'd0,
    OUT_DELAY     = 2'd1,
    OUT_ACK       = 2'd2,
    OUT_WAIT_FALL = 2'd3
  } out_state_t;

  // --------------------------------------------------------------------------
  // Synchronisers for the asynchronous ai / ro inputs
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ai_sync_q, ai_sync_d;
  logic [SYNC_STAGES-1:0] ro_sync_q, ro_sync_d;
  logic                   ai_prev_q, ai_prev_d;
  logic                   ai_s;
  logic                   ro_s;

  assign ai_s = ai_sync_q[SYNC_STAGES-1];
  assign ro_s = ro_sync_q[SYNC_STAGES-1];

  // Shift the raw inputs through the synchroniser chains; ai_prev gives the
  // previous synchronised ai level for rising-edge detection.
  always_comb begin
    ai_sync_d = {ai_sync_q[SYNC_STAGES-2:0], ai};
    ro_sync_d = {ro_sync_q[SYNC_STAGES-2:0], ro};
    ai_prev_d = ai_s;
  end

  // Synchroniser and edge-detect flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ai_sync_q <= '0;
      ro_sync_q <= '0;
      ai_prev_q <= 1'b0;
    end else begin
      ai_sync_q <= ai_sync_d;
      ro_sync_q <= ro_sync_d;
      ai_prev_q <= ai_prev_d;
    end
  end

  // --------------------------------------------------------------------------
  // State registers (declared up front so the error detector can see both)
  // --------------------------------------------------------------------------
  in_state_t          in_state_q, in_state_d;
  logic               ri_q, ri_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   n_req_q, n_req_d;
  logic [CNT_W-1:0]   req_count_q, req_count_d;
  logic [c_tmo_w-1:0] tmo_cnt_q, tmo_cnt_d;
  logic               proto_err_q, proto_err_d;
  logic [1:0]         err_code_q, err_code_d;

  out_state_t         out_state_q, out_state_d;
  logic               ao_q, ao_d;
  logic [c_dly_w-1:0] dly_cnt_q, dly_cnt_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  // --------------------------------------------------------------------------
  // Protocol error detection
  // --------------------------------------------------------------------------
  logic             err_tmo;
  logic             err_spur;
  logic             err_ro;
  logic             any_err;
  logic [CNT_W-1:0] req_next;

  assign req_next = req_count_q + 1'b1;

  // Timeout fires once the wait counter has already spent TIMEOUT cycles and
  // the awaited level is still absent; a rising ai_s is only legal in REQ_UP.
  always_comb begin
    err_tmo  = (((in_state_q == IN_REQ_UP) && !ai_s) ||
                ((in_state_q == IN_REQ_DN) &&  ai_s)) &&
               (tmo_cnt_q == c_tmo_max);
    err_spur = ai_s && !ai_prev_q &&
               ((in_state_q == IN_IDLE) || (in_state_q == IN_REQ_DN) ||
                (in_state_q == IN_FIN));
    err_ro   = (out_state_q == OUT_DELAY) && !ro_s;
    any_err  = err_tmo || err_spur || err_ro;
  end

  // Sticky error flag: only the first error is recorded.
  always_comb begin
    proto_err_d = proto_err_q;
    err_code_d  = err_code_q;
    if (!proto_err_q && any_err) begin
      proto_err_d = 1'b1;
      if (err_tmo) begin
        err_code_d = c_err_tmo;
      end else if (err_spur) begin
        err_code_d = c_err_spur;
      end else begin
        err_code_d = c_err_ro;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Input-channel initiator FSM
  // --------------------------------------------------------------------------
  // Next-state logic; outputs are computed for the state being entered so
  // that ri/busy/done come straight from flops.
  always_comb begin
    in_state_d  = in_state_q;
    ri_d        = ri_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    n_req_d     = n_req_q;
    req_count_d = req_count_q;
    tmo_cnt_d   = tmo_cnt_q;

    unique case (in_state_q)
      IN_IDLE: begin
        if (start) begin
          n_req_d     = n_req;
          req_count_d = '0;
          tmo_cnt_d   = '0;
          if (n_req == '0) begin
            in_state_d = IN_FIN;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            in_state_d = IN_REQ_UP;
            busy_d     = 1'b1;
            ri_d       = 1'b1;
          end
        end
      end
      IN_REQ_UP: begin
        if (ai_s) begin
          in_state_d = IN_REQ_DN;
          ri_d       = 1'b0;
          tmo_cnt_d  = '0;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + 1'b1;
        end
      end
      IN_REQ_DN: begin
        if (!ai_s) begin
          req_count_d = req_next;
          tmo_cnt_d   = '0;
          if (req_next == n_req_q) begin
            in_state_d = IN_FIN;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            in_state_d = IN_REQ_UP;
            ri_d       = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      IN_FIN: begin
        // start here is deliberately not looked at
        in_state_d = IN_IDLE;
      end
      IN_ERR: begin
        // Terminal until reset: ri and busy simply hold
      end
      default: begin
        in_state_d = IN_IDLE;
      end
    endcase

    // Any error freezes the initiator where it stands.
    if (any_err && (in_state_q != IN_ERR)) begin
      in_state_d  = IN_ERR;
      ri_d        = ri_q;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      n_req_d     = n_req_q;
      req_count_d = req_count_q;
      tmo_cnt_d   = tmo_cnt_q;
    end
  end

  // Initiator and error flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q  <= IN_IDLE;
      ri_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      n_req_q     <= '0;
      req_count_q <= '0;
      tmo_cnt_q   <= '0;
      proto_err_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      in_state_q  <= in_state_d;
      ri_q        <= ri_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      n_req_q     <= n_req_d;
      req_count_q <= req_count_d;
      tmo_cnt_q   <= tmo_cnt_d;
      proto_err_q <= proto_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output-channel responder FSM (free running, never gated by busy/errors)
  // --------------------------------------------------------------------------
  // Next-state logic; ao is set on entry to ACK and cleared on ro_s fall.
  always_comb begin
    out_state_d = out_state_q;
    ao_d        = ao_q;
    dly_cnt_d   = dly_cnt_q;
    out_count_d = out_count_q;

    unique case (out_state_q)
      OUT_WAIT_RISE: begin
        if (ro_s) begin
          if (ACK_DELAY == 0) begin
            out_state_d = OUT_ACK;
            ao_d        = 1'b1;
          end else begin
            out_state_d = OUT_DELAY;
            dly_cnt_d   = '0;
          end
        end
      end
      OUT_DELAY: begin
        if (!ro_s) begin
          // Request withdrawn before acknowledge: abandon this handshake
          out_state_d = OUT_WAIT_RISE;
        end else if (dly_cnt_q == c_dly_last) begin
          out_state_d = OUT_ACK;
          ao_d        = 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end
      OUT_ACK: begin
        out_state_d = OUT_WAIT_FALL;
      end
      OUT_WAIT_FALL: begin
        if (!ro_s) begin
          out_state_d = OUT_WAIT_RISE;
          ao_d        = 1'b0;
          out_count_d = out_count_q + 1'b1;
        end
      end
      default: begin
        out_state_d = OUT_WAIT_RISE;
        ao_d        = 1'b0;
      end
    endcase
  end

  // Responder flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q <= OUT_WAIT_RISE;
      ao_q        <= 1'b0;
      dly_cnt_q   <= '0;
      out_count_q <= '0;
    end else begin
      out_state_q <= out_state_d;
      ao_q        <= ao_d;
      dly_cnt_q   <= dly_cnt_d;
      out_count_q <= out_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ri        = ri_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ao        = ao_q;
  assign req_count = req_count_q;
  assign out_count = out_count_q;
  assign proto_err = proto_err_q;
  assign err_code  = err_code_q;

endmodule
`default_nettype wire
